// File: rtl/minisrc_pkg.sv
// Shared Mini SRC definitions: bus width, the bus word type, the default
// out-port FIFO depth and the I/O port addresses used by the CPU's in/out
// port decode.
package minisrc_pkg;

  // Width of the CPU bus and of every out-port word.
  localparam int DATA_W = 32;

  // One CPU bus word.
  typedef logic [DATA_W-1:0] word_t;

  // Default number of buffered out-port words (power of two, at least 2).
  localparam int OUT_FIFO_DEPTH = 4;

  // I/O port addresses; the in-port and the out-port share this address map.
  localparam logic [3:0] IN_PORT_ADDR  = 4'd0;
  localparam logic [3:0] OUT_PORT_ADDR = 4'd1;

endpackage

// File: rtl/outport_fifo_core.sv
// Storage core of the out-port buffer: a DEPTH-entry circular FIFO with a
// show-ahead head word, an occupancy count and full/empty flags. The caller
// guarantees push never happens when full without a pop, and pop never happens
// when empty.
module outport_fifo_core
  import minisrc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full
);

  // DEPTH is a power of two, so pointers wrap naturally at AW bits.
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  // Storage: cleared on reset so the head word reads zero; written on push.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep count.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Show-ahead head word and flags derived directly from registered state.
  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);

endmodule

// File: rtl/out_port_buffer.sv
// Out-port buffer for the Mini SRC CPU. Every OutPort_en strobe deposits the
// bus word into a small FIFO that an external consumer drains over a
// valid/ready handshake, so a slow sink never stalls the CPU. Writes that
// arrive while the FIFO is full (and not draining that cycle) are dropped and
// latch the sticky overflow flag.
// Build option: define OUT_PORT_ECHO_EN to add out_port_last, a register that
// holds the most recently accepted word (the classic out-port display value).
module out_port_buffer
#(
  parameter int DATA_W = minisrc_pkg::DATA_W,
  parameter int DEPTH  = minisrc_pkg::OUT_FIFO_DEPTH
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              OutPort_en,
  input  logic [DATA_W-1:0] BusMux_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              full,
  output logic              overflow
`ifdef OUT_PORT_ECHO_EN
  ,
  output logic [DATA_W-1:0] out_port_last
`endif
);
  import minisrc_pkg::*;

  logic push;
  logic pop;
  logic fifo_empty;
  logic fifo_full;
  logic overflow_reg;

  // A pop only happens with data present; a full FIFO still accepts a word in
  // the same cycle it hands one out, which keeps one-word-per-cycle streaming.
  assign pop  = out_valid && out_ready;
  assign push = OutPort_en && (!fifo_full || pop);

  outport_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .Clock   (Clock),
    .Reset   (Reset),
    .push    (push),
    .pop     (pop),
    .wr_data (BusMux_out),
    .rd_data (out_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign full      = fifo_full;

  // Sticky drop indicator: set by any strobe that could not be accepted.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      overflow_reg <= 1'b0;
    end else if (OutPort_en && !push) begin
      overflow_reg <= 1'b1;
    end
  end

  assign overflow = overflow_reg;

`ifdef OUT_PORT_ECHO_EN
  logic [DATA_W-1:0] last_reg;

  // Echo register follows accepted words only; dropped writes leave it alone.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      last_reg <= '0;
    end else if (push) begin
      last_reg <= BusMux_out;
    end
  end

  assign out_port_last = last_reg;
`endif

endmodule

// File: tb/tb_out_port_buffer.sv
// Self-checking bench for out_port_buffer: a queue scoreboard models the FIFO,
// expected words are queued when a strobe is accepted and compared when the
// consumer pops them.
module tb_out_port_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        Reset;
  logic        OutPort_en;
  logic [31:0] BusMux_out;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        full;
  logic        overflow;
`ifdef OUT_PORT_ECHO_EN
  logic [31:0] out_port_last;
`endif

  int errors = 0;
  int checks = 0;
  int pops   = 0;

  logic [31:0] exp_q[$];
  logic        m_overflow = 1'b0;
  logic [31:0] m_last     = '0;

  out_port_buffer #(
    .DATA_W (32),
    .DEPTH  (DEPTH)
  ) dut (
    .Clock         (clk),
    .Reset         (Reset),
    .OutPort_en    (OutPort_en),
    .BusMux_out    (BusMux_out),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .full          (full),
    .overflow      (overflow)
`ifdef OUT_PORT_ECHO_EN
    ,
    .out_port_last (out_port_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: check current outputs against the model, drive inputs,
  // update the model, advance past the edge.
  task automatic cycle(input logic en, input logic [31:0] d, input logic rdy);
    logic m_pop;
    logic m_push;
    OutPort_en = en;
    BusMux_out = d;
    out_ready  = rdy;
    checks++;
    if (out_valid !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b", out_valid, exp_q.size() != 0);
    end
    checks++;
    if (full !== (exp_q.size() == DEPTH)) begin
      errors++;
      $display("FAIL full: got %b expected %b", full, exp_q.size() == DEPTH);
    end
    checks++;
    if (overflow !== m_overflow) begin
      errors++;
      $display("FAIL overflow: got %b expected %b", overflow, m_overflow);
    end
    if (exp_q.size() != 0) begin
      checks++;
      if (out_data !== exp_q[0]) begin
        errors++;
        $display("FAIL head_word: got %h expected %h", out_data, exp_q[0]);
      end
    end
`ifdef OUT_PORT_ECHO_EN
    checks++;
    if (out_port_last !== m_last) begin
      errors++;
      $display("FAIL echo_last: got %h expected %h", out_port_last, m_last);
    end
`endif
    m_pop  = (exp_q.size() != 0) && rdy;
    m_push = en && ((exp_q.size() < DEPTH) || m_pop);
    if (m_pop) begin
      $display("pop  %h", exp_q[0]);
      void'(exp_q.pop_front());
      pops++;
    end
    if (m_push) begin
      exp_q.push_back(d);
      m_last = d;
      $display("push %h accepted", d);
    end else if (en) begin
      m_overflow = 1'b1;
      $display("push %h dropped", d);
    end
    @(posedge clk);
    #1;
    OutPort_en = 1'b0;
    out_ready  = 1'b0;
  endtask

  task automatic test_reset();
    Reset      = 1'b1;
    OutPort_en = 1'b0;
    BusMux_out = '0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", full); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", out_data); end
`ifdef OUT_PORT_ECHO_EN
    checks++;
    if (out_port_last !== 32'h0) begin errors++; $display("FAIL rst_last: got %h expected 0", out_port_last); end
`endif
  endtask

  task automatic test_single_push();
    cycle(1'b1, 32'h0000_00A5, 1'b0);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    checks++;
    if (out_data !== 32'h0000_00A5) begin errors++; $display("FAIL single_data: got %h expected 000000a5", out_data); end
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL single_full: got %b expected 0", full); end
    cycle(1'b0, 32'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", out_valid); end
  endtask

  task automatic fill_four(input logic [31:0] base);
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, base * i, 1'b0);
    end
  endtask

  task automatic test_full_pop_push();
    fill_four(32'h11);
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL fpp_full_before: got %b expected 1", full); end
    cycle(1'b1, 32'h66, 1'b1);
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL fpp_full_after: got %b expected 1", full); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow: got %b expected 0", overflow); end
    checks++;
    if (out_data !== 32'h22) begin errors++; $display("FAIL fpp_head: got %h expected 00000022", out_data); end
    repeat (4) cycle(1'b0, 32'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL fpp_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_overflow();
    fill_four(32'h11);
    cycle(1'b1, 32'h55, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
    repeat (4) cycle(1'b0, 32'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", out_valid); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_back_to_back();
    int pops_before;
    pops_before = pops;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 32'(i), 1'b1);
    end
    cycle(1'b0, 32'h0, 1'b1);
    checks++;
    if (pops - pops_before !== 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", pops - pops_before); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    fill_four(32'hAA);
    #3 Reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL midrst_full: got %b expected 0", full); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow: got %b expected 0", overflow); end
    exp_q.delete();
    m_overflow = 1'b0;
    m_last     = '0;
    @(posedge clk);
    #1 Reset = 1'b0;
    #1;
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h expected 0", out_data); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid_after: got %b expected 0", out_valid); end
    $display("reset asserted mid-cycle, contents discarded");
  endtask

`ifdef OUT_PORT_ECHO_EN
  task automatic test_echo();
    cycle(1'b1, 32'h1, 1'b0);
    cycle(1'b1, 32'h2, 1'b0);
    cycle(1'b1, 32'h3, 1'b0);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
    cycle(1'b1, 32'h0000_0BAD, 1'b0);
    checks++;
    if (out_port_last !== 32'hDEAD_BEEF) begin errors++; $display("FAIL echo_hold: got %h expected deadbeef", out_port_last); end
    repeat (4) cycle(1'b0, 32'h0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_single_push();
    test_full_pop_push();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_back_to_back();
`ifdef OUT_PORT_ECHO_EN
    test_echo();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
